// File: rtl/ram_be_sp_init.sv
// ram_be_sp_init: 1W/1R byte-enabled data RAM that zero-scrubs itself after reset. Optional macro RAM_OUT_REG_EN.
// Latency: rd_data_o/rd_valid_o 1 cycle after rd_en_i (2 cycles when RAM_OUT_REG_EN is defined).
// Backpressure: none; one read and one write per cycle once init_done_o is high. Accesses during scrub are dropped.
module ram_be_sp_init #(
  parameter int  DATA_WIDTH     = 32,
  parameter int  ADDR_WIDTH     = 32,
  parameter int  RAM_ADDR_WIDTH = 12,
  localparam int LANES          = DATA_WIDTH / 8,
  localparam int LSB            = $clog2(LANES),
  localparam int IDX_W          = RAM_ADDR_WIDTH - LSB,
  localparam int DEPTH          = 2 ** IDX_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LANES-1:0]      wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  output logic                  init_done_o
);

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t               state, state_nxt;
  logic [IDX_W-1:0]     cnt, cnt_nxt;

  logic [IDX_W-1:0]     wr_idx, rd_idx;
  logic [LANES-1:0]     mem_we;
  logic [IDX_W-1:0]     mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                 rd_acc;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_q;
  logic [LANES-1:0]      fwd_mask;
  logic [DATA_WIDTH-1:0] fwd_data;
  logic [DATA_WIDTH-1:0] fwd_bits;
  logic [DATA_WIDTH-1:0] rd_mux;
  logic                  rd_valid_q;

  // Only the word-index slice of each address is decoded; the rest aliases.
  assign wr_idx = wr_addr_i[RAM_ADDR_WIDTH-1:LSB];
  assign rd_idx = rd_addr_i[RAM_ADDR_WIDTH-1:LSB];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{wr_addr_i, rd_addr_i};

  // Control state and scrub counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state and RAM write-port steering: scrub writes own the port during INIT.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mem_we    = '0;
    mem_waddr = wr_idx;
    mem_wdata = wr_data_i;
    rd_acc    = 1'b0;
    case (state)
      S_INIT: begin
        mem_we    = '1;
        mem_waddr = cnt;
        mem_wdata = '0;
        cnt_nxt   = cnt + IDX_W'(1);
        if (cnt == IDX_W'(DEPTH - 1)) state_nxt = S_RUN;
      end
      S_RUN: begin
        mem_we = wr_en_i;
        rd_acc = rd_en_i;
      end
      default: state_nxt = S_INIT;
    endcase
  end

  assign init_done_o = (state == S_RUN);

  // Byte-enabled write into the array; no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    for (int k = 0; k < LANES; k++) begin
      if (mem_we[k]) mem[mem_waddr][8*k +: 8] <= mem_wdata[8*k +: 8];
    end
  end

  // Synchronous read plus capture of same-word write lanes for write-first forwarding.
  always_ff @(posedge clk) begin
    if (rd_acc) begin
      rd_q     <= mem[rd_idx];
      fwd_mask <= (wr_idx == rd_idx) ? wr_en_i : '0;
      fwd_data <= wr_data_i;
    end
  end

  // Read-valid tracking; reset discards any read in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_valid_q <= 1'b0;
    else     rd_valid_q <= rd_acc;
  end

  // Expand the lane mask and merge forwarded bytes over the array's old data.
  always_comb begin
    fwd_bits = '0;
    for (int k = 0; k < LANES; k++) begin
      fwd_bits[8*k +: 8] = {8{fwd_mask[k]}};
    end
    rd_mux = (rd_q & ~fwd_bits) | (fwd_data & fwd_bits);
  end

`ifdef RAM_OUT_REG_EN
  logic [DATA_WIDTH-1:0] out_q;
  logic                  out_vld;

  // Extra output stage; only loads on a valid read so it also holds the last word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q   <= '0;
      out_vld <= 1'b0;
    end else begin
      out_vld <= rd_valid_q;
      if (rd_valid_q) out_q <= rd_mux;
    end
  end

  assign rd_data_o  = out_q;
  assign rd_valid_o = out_vld;
`else
  logic [DATA_WIDTH-1:0] rd_hold;

  // Remember the last delivered word so rd_data_o holds between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             rd_hold <= '0;
    else if (rd_valid_q) rd_hold <= rd_mux;
  end

  assign rd_data_o  = rd_valid_q ? rd_mux : rd_hold;
  assign rd_valid_o = rd_valid_q;
`endif

endmodule

// File: tb/tb_ram_be_sp_init.sv
module tb_ram_be_sp_init;

  localparam int DEPTH = 1024;
`ifdef RAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  wr_en_i = '0;
  logic [31:0] wr_addr_i = '0;
  logic [31:0] wr_data_i = '0;
  logic        rd_en_i = 1'b0;
  logic [31:0] rd_addr_i = '0;
  logic [31:0] rd_data_o;
  logic        rd_valid_o;
  logic        init_done_o;

  ram_be_sp_init dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en_i     (wr_en_i),
    .wr_addr_i   (wr_addr_i),
    .wr_data_i   (wr_data_i),
    .rd_en_i     (rd_en_i),
    .rd_addr_i   (rd_addr_i),
    .rd_data_o   (rd_data_o),
    .rd_valid_o  (rd_valid_o),
    .init_done_o (init_done_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: plain word array, edge count since reset release, read pipeline.
  logic [31:0] model [DEPTH];
  int          edges;
  bit          pv [2];
  logic [31:0] pd [2];
  logic [31:0] exp_hold;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    edges    = 0;
    pv[0]    = 0;
    pv[1]    = 0;
    exp_hold = '0;
    for (int i = 0; i < DEPTH; i++) model[i] = 'x;
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a % 32'd4096) / 32'd4);
  endfunction

  // One clock: predict from the current inputs, advance, then compare all outputs.
  task automatic cycle();
    bit          run, issued;
    logic [31:0] val;
    int          ri, wi;
    run    = (edges >= DEPTH);
    issued = run && rd_en_i;
    ri     = widx(rd_addr_i);
    wi     = widx(wr_addr_i);
    val    = model[ri];
    if (run) begin
      for (int k = 0; k < 4; k++) begin
        if (wr_en_i[k]) begin
          if (wi == ri) val[8*k +: 8] = wr_data_i[8*k +: 8];
          model[wi][8*k +: 8] = wr_data_i[8*k +: 8];
        end
      end
    end
    @(posedge clk);
    #1;
    edges++;
    if (edges == DEPTH) for (int i = 0; i < DEPTH; i++) model[i] = '0;
    pv[1] = pv[0];
    pd[1] = pd[0];
    pv[0] = issued;
    pd[0] = val;
    if (pv[LAT-1]) exp_hold = pd[LAT-1];
    check("rd_valid", 32'(rd_valid_o), 32'(pv[LAT-1]));
    check("rd_data", rd_data_o, exp_hold);
    check("init_done", 32'(init_done_o), 32'(edges >= DEPTH));
  endtask

  task automatic set_idle();
    wr_en_i = '0;
    rd_en_i = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] en);
    set_idle();
    wr_addr_i = a;
    wr_data_i = d;
    wr_en_i   = en;
    cycle();
  endtask

  // Issue one read, wait out the latency, compare against a fixed expected word.
  task automatic read_expect(input string tag, input logic [31:0] a, input logic [31:0] exp);
    set_idle();
    rd_addr_i = a;
    rd_en_i   = 1'b1;
    cycle();
    set_idle();
    for (int i = 1; i < LAT; i++) cycle();
    check({tag, "_vld"}, 32'(rd_valid_o), 32'd1);
    check(tag, rd_data_o, exp);
  endtask

  task automatic release_and_scrub(input bit poke);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    wr_addr_i = 32'h0;
    wr_data_i = 32'hFFFF_FFFF;
    wr_en_i   = poke ? 4'hF : 4'h0;
    rd_addr_i = 32'h0;
    rd_en_i   = 1'b1;
    for (int i = 0; i < DEPTH; i++) cycle();
    set_idle();
  endtask

  logic [31:0] r, a;

  initial begin
    model_reset();
    #1;
    check("rst_rd_valid", 32'(rd_valid_o), 32'd0);
    check("rst_rd_data", rd_data_o, 32'd0);
    check("rst_init_done", 32'(init_done_o), 32'd0);
    @(posedge clk);

    // Scrub while hammering writes/reads at word 0; none may take effect.
    release_and_scrub(1'b1);
    check("scrub_done", 32'(init_done_o), 32'd1);
    read_expect("scrub_w0", 32'h0000_0000, 32'h0);
    read_expect("scrub_w511", 32'h0000_07FC, 32'h0);
    read_expect("scrub_w1023", 32'h0000_0FFC, 32'h0);

    do_write(32'h010, 32'hDEAD_BEEF, 4'hF);
    do_write(32'h010, 32'h1122_3344, 4'b0101);
    read_expect("byte_lane", 32'h010, 32'hDE22_BE44);

    do_write(32'h020, 32'hAAAA_AAAA, 4'hF);
    wr_addr_i = 32'h020;
    wr_data_i = 32'h5555_5555;
    wr_en_i   = 4'b0011;
    rd_addr_i = 32'h020;
    rd_en_i   = 1'b1;
    cycle();
    set_idle();
    for (int i = 1; i < LAT; i++) cycle();
    check("collision", rd_data_o, 32'hAAAA_5555);
    read_expect("collision_after", 32'h020, 32'hAAAA_5555);

    do_write(32'h0000_1004, 32'hCAFE_F00D, 4'hF);
    read_expect("alias", 32'h0000_0007, 32'hCAFE_F00D);

    do_write(32'h100, 32'h0BAD_CAFE, 4'hF);
    read_expect("read_after_write", 32'h100, 32'h0BAD_CAFE);
    do_write(32'h104, 32'h1234_5678, 4'h0);
    read_expect("wr_en_zero", 32'h104, 32'h0);

    // Random traffic on a small word window so collisions and back-to-back reads are frequent.
    for (int i = 0; i < 3000; i++) begin
      r         = $urandom;
      a         = (r & 32'hFFFF_F003) | (32'($urandom_range(0, 15)) << 2);
      wr_addr_i = a;
      r         = $urandom;
      a         = (r & 32'hFFFF_F003) | (32'($urandom_range(0, 15)) << 2);
      rd_addr_i = a;
      wr_data_i = $urandom;
      wr_en_i   = 4'($urandom_range(0, 15));
      rd_en_i   = ($urandom_range(0, 3) != 0);
      cycle();
    end

    // Reset in the middle of a read stream.
    set_idle();
    rd_en_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rd_addr_i = 32'($urandom_range(0, 15)) << 2;
      cycle();
    end
    rst = 1'b1;
    #1;
    check("mid_rst_rd_valid", 32'(rd_valid_o), 32'd0);
    check("mid_rst_rd_data", rd_data_o, 32'd0);
    check("mid_rst_init_done", 32'(init_done_o), 32'd0);
    release_and_scrub(1'b0);
    check("rescrub_done", 32'(init_done_o), 32'd1);
    read_expect("rescrub_w16", 32'h0000_0040, 32'h0);
    read_expect("rescrub_w4", 32'h0000_0010, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
